// File: rtl/operand_recover.sv
// operand_recover
//   Rebuilds a signed operand pair (a, b) from a stream of tagged results of
//   the 4-way select/add/sub datapath. The tags are 00=a, 01=b, 10=a+b and
//   11=a-b. Any two words with different tags resolve the pair. The first
//   word is held. A later word with the same tag overwrites it. A word with a
//   different tag completes the pair, and the pair is registered on the output.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   clr                   drop any held partial word; err_cnt is kept
//   in_valid/in_ready     input handshake
//   in_tag, in_data       tag and signed DW+1 bit result word
//   out_valid/out_ready   output handshake; the pair is held until accepted
//   out_a, out_b          recovered operands, wrapped to DW bits
//   out_err               pair failed the parity, range or extension check
//   err_cnt               saturating count of emitted pairs with out_err=1
module operand_recover #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_tag,
    input  logic signed [DW:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_a,
    output logic signed [DW-1:0]    out_b,
    output logic                    out_err,
    output logic [CNT_W-1:0]        err_cnt
);
    // DW+2 bits hold any sum or difference of two DW+1 bit words without overflow.
    localparam int W2    = DW + 2;
    localparam int MIN_I = -(2 ** (DW - 1));
    localparam int MAX_I = (2 ** (DW - 1)) - 1;
    localparam logic signed [W2-1:0] MIN_V = W2'(MIN_I);
    localparam logic signed [W2-1:0] MAX_V = W2'(MAX_I);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                state, state_nxt;
    logic [1:0]            hold_tag_p0;
    logic signed [DW:0]    hold_data_p0;
    logic                  hold_err_p0;

    logic                  accept, pair_done, same_tag;
    logic [3:0]            present;
    logic signed [W2-1:0]  va, vb, vs, vd, sum, dif, rec_a, rec_b;
    logic                  par_err, pair_err;

    function automatic logic signed [W2-1:0] sext(input logic signed [DW:0] x);
        return {x[DW], x};
    endfunction

    function automatic logic in_range(input logic signed [W2-1:0] x);
        return (x >= MIN_V) && (x <= MAX_V);
    endfunction

    // A direct operand word must be a sign-extended DW-bit value.
    function automatic logic ext_err(input logic [1:0] tag, input logic signed [DW:0] x);
        return !tag[1] && (x[DW] != x[DW-1]);
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !clr;
    assign same_tag  = (in_tag == hold_tag_p0);
    assign pair_done = accept && (state == HOLD) && !same_tag;

    // Pair resolution. Each word goes into a slot chosen by its tag, so the
    // result does not depend on the order in which the words arrived.
    always_comb begin
        va      = '0;
        vb      = '0;
        vs      = '0;
        vd      = '0;
        sum     = '0;
        dif     = '0;
        rec_a   = '0;
        rec_b   = '0;
        par_err = 1'b0;
        present = 4'b0000;
        present[hold_tag_p0] = 1'b1;
        present[in_tag]      = 1'b1;
        case (hold_tag_p0)
            2'b00:   va = sext(hold_data_p0);
            2'b01:   vb = sext(hold_data_p0);
            2'b10:   vs = sext(hold_data_p0);
            default: vd = sext(hold_data_p0);
        endcase
        case (in_tag)
            2'b00:   va = sext(in_data);
            2'b01:   vb = sext(in_data);
            2'b10:   vs = sext(in_data);
            default: vd = sext(in_data);
        endcase
        case (present)
            4'b0011: begin rec_a = va;      rec_b = vb;      end
            4'b0101: begin rec_a = va;      rec_b = vs - va; end
            4'b1001: begin rec_a = va;      rec_b = va - vd; end
            4'b0110: begin rec_a = vs - vb; rec_b = vb;      end
            4'b1010: begin rec_a = vd + vb; rec_b = vb;      end
            4'b1100: begin
                sum     = vs + vd;
                dif     = vs - vd;
                rec_a   = sum >>> 1;
                rec_b   = dif >>> 1;
                par_err = sum[0];
            end
            default: ;
        endcase
        pair_err = hold_err_p0 | ext_err(in_tag, in_data) | par_err
                 | !in_range(rec_a) | !in_range(rec_b);
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = EMPTY;
        end else if (accept) begin
            if (state == EMPTY || same_tag) state_nxt = HOLD;
            else                            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Held word stage. Its extension flag stays with it until the pair resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_tag_p0  <= '0;
            hold_data_p0 <= '0;
            hold_err_p0  <= 1'b0;
        end else if (accept && (state == EMPTY || same_tag)) begin
            hold_tag_p0  <= in_tag;
            hold_data_p0 <= in_data;
            hold_err_p0  <= ext_err(in_tag, in_data);
        end
    end

    // Output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (pair_done) begin
                out_valid <= 1'b1;
                out_a     <= rec_a[DW-1:0];
                out_b     <= rec_b[DW-1:0];
                out_err   <= pair_err;
                if (pair_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_recover.sv
module tb_operand_recover;
    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_tag;
    logic signed [8:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_a;
    logic signed [7:0] out_b;
    logic              out_err;
    logic [7:0]        err_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    operand_recover #(.DW(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_err(out_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t1;
        int         d1;
        logic [1:0] t2;
        int         d2;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ee;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; it returns at the same phase.
    task automatic send(input logic [1:0] t, input int d);
        in_valid = 1'b1;
        in_tag   = t;
        in_data  = 9'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                              input logic ee);
        if (ee && exp_cnt < 255) exp_cnt++;
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".a"},     32'(out_a[7:0]), 32'(ea));
        chk({nm, ".b"},     32'(out_b[7:0]), 32'(eb));
        chk({nm, ".err"},   32'(out_err), 32'(ee));
        chk({nm, ".cnt"},   32'(err_cnt), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.a",     32'(out_a[7:0]), 32'd0);
        chk("rst.b",     32'(out_b[7:0]), 32'd0);
        chk("rst.err",   32'(out_err), 32'd0);
        chk("rst.cnt",   32'(err_cnt), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
    endtask

    // Reference: place the two words by tag and solve a and b with plain integers.
    function automatic int floor_half(input int x);
        return (x >= 0) ? x / 2 : -((-x + 1) / 2);
    endfunction

    function automatic void model(input logic [1:0] t1, input int d1, input logic [1:0] t2,
                                  input int d2, output logic [7:0] ea, output logic [7:0] eb,
                                  output logic ee);
        int v[4];
        int a, b;
        logic [31:0] ta, tb;
        logic [3:0] has;
        v = '{default: 0};
        has = 4'b0;
        ee = 1'b0;
        v[t1] = d1;
        v[t2] = d2;
        has[t1] = 1'b1;
        has[t2] = 1'b1;
        if (t1 < 2 && (d1 < -128 || d1 > 127)) ee = 1'b1;
        if (t2 < 2 && (d2 < -128 || d2 > 127)) ee = 1'b1;
        a = 0;
        b = 0;
        if (has[0] && has[1])      begin a = v[0]; b = v[1]; end
        else if (has[0] && has[2]) begin a = v[0]; b = v[2] - a; end
        else if (has[0] && has[3]) begin a = v[0]; b = a - v[3]; end
        else if (has[1] && has[2]) begin b = v[1]; a = v[2] - b; end
        else if (has[1] && has[3]) begin b = v[1]; a = v[3] + b; end
        else begin
            if (((v[2] + v[3]) % 2) != 0) ee = 1'b1;
            a = floor_half(v[2] + v[3]);
            b = floor_half(v[2] - v[3]);
        end
        if (a < -128 || a > 127 || b < -128 || b > 127) ee = 1'b1;
        ta = a;
        tb = b;
        ea = ta[7:0];
        eb = tb[7:0];
    endfunction

    function automatic int fwd(input logic [1:0] t, input int a, input int b);
        case (t)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return a + b;
            default: return a - b;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{2'd2, 2,    2'd3, 8,    8'h05, 8'hFD, 1'b0};
        vecs[1]  = '{2'd3, 0,    2'd2, 3,    8'h01, 8'h01, 1'b1};
        vecs[2]  = '{2'd2, 3,    2'd3, 0,    8'h01, 8'h01, 1'b1};
        vecs[3]  = '{2'd0, 127,  2'd2, -2,   8'h7F, 8'h7F, 1'b1};
        vecs[4]  = '{2'd0, -5,   2'd1, 7,    8'hFB, 8'h07, 1'b0};
        vecs[5]  = '{2'd1, -1,   2'd3, 10,   8'h09, 8'hFF, 1'b0};
        vecs[6]  = '{2'd0, 128,  2'd1, 0,    8'h80, 8'h00, 1'b1};
        vecs[7]  = '{2'd1, 20,   2'd2, -100, 8'h88, 8'h14, 1'b0};
        vecs[8]  = '{2'd0, 100,  2'd3, -27,  8'h64, 8'h7F, 1'b0};
        vecs[9]  = '{2'd2, -256, 2'd3, 0,    8'h80, 8'h80, 1'b0};
        vecs[10] = '{2'd2, 255,  2'd3, -1,   8'h7F, 8'h80, 1'b1};

        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_tag = '0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.cnt",   32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        idle();

        // Table vectors: the first word must not produce output, the second must.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].t1, vecs[i].d1);
            chk($sformatf("vec%0d.first", i), 32'(out_valid), 32'd0);
            send(vecs[i].t2, vecs[i].d2);
            check_pair($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ee);
            idle();
        end

        // Backpressure: a third word stalls until the pending pair is taken.
        out_ready = 1'b0;
        send(2'd0, 10);
        send(2'd1, 20);
        check_pair("stall", 8'd10, 8'd20, 1'b0);
        chk("stall.ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_tag   = 2'd2;
        in_data  = 9'd99;
        repeat (3) idle();
        chk("stall.hold_valid", 32'(out_valid), 32'd1);
        chk("stall.hold_a",     32'(out_a[7:0]), 32'd10);
        out_ready = 1'b1;
        #1;
        chk("stall.release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall.popped", 32'(out_valid), 32'd0);
        send(2'd3, 1);
        check_pair("stall.next", 8'd50, 8'd49, 1'b0);
        idle();

        // Overwrite with a repeated tag, then clr dropping a held word.
        send(2'd0, 4);
        send(2'd0, 9);
        chk("ovr.first", 32'(out_valid), 32'd0);
        send(2'd1, -1);
        check_pair("ovr", 8'd9, 8'hFF, 1'b0);
        send(2'd0, 50);
        clr = 1'b1;
        send(2'd1, 1);
        clr = 1'b0;
        chk("clr.dropped", 32'(out_valid), 32'd0);
        send(2'd1, 3);
        chk("clr.first", 32'(out_valid), 32'd0);
        send(2'd0, 2);
        check_pair("clr.next", 8'd2, 8'd3, 1'b0);

        // Reset while an error pair is pending, and again while a word is held.
        out_ready = 1'b0;
        idle();
        out_ready = 1'b1;
        send(2'd0, 128);
        out_ready = 1'b0;
        send(2'd1, 0);
        check_pair("pre_rst", 8'h80, 8'h00, 1'b1);
        do_reset();
        out_ready = 1'b1;
        send(2'd2, 6);
        do_reset();
        send(2'd3, 2);
        chk("rst.hold_gone", 32'(out_valid), 32'd0);
        do_reset();

        // Saturation of the error counter.
        for (int i = 0; i < 255; i++) begin
            send(2'd0, 128);
            send(2'd1, 0);
            if (exp_cnt < 255) exp_cnt++;
        end
        chk("sat.255", 32'(err_cnt), 32'd255);
        send(2'd1, 0);
        send(2'd0, -129);
        check_pair("sat.256", 8'h7F, 8'h00, 1'b1);
        do_reset();

        // Randomized pairs against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [1:0] t1, t2;
            int d1, d2, a, b;
            logic [7:0] ea, eb;
            logic ee, fw;
            t1 = 2'($urandom_range(0, 3));
            t2 = 2'((int'(t1) + int'($urandom_range(1, 3))) % 4);
            fw = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            if (fw) begin
                d1 = fwd(t1, a, b);
                d2 = fwd(t2, a, b);
            end else begin
                d1 = int'($urandom_range(0, 511)) - 256;
                d2 = int'($urandom_range(0, 511)) - 256;
            end
            model(t1, d1, t2, d2, ea, eb, ee);
            send(t1, d1);
            chk($sformatf("rnd%0d.first", n), 32'(out_valid), 32'd0);
            if ($urandom_range(0, 3) == 0) idle();
            send(t2, d2);
            check_pair($sformatf("rnd%0d t%0d=%0d t%0d=%0d", n, t1, d1, t2, d2), ea, eb, ee);
            if (fw) begin
                chk($sformatf("rnd%0d.orig_a", n), 32'(out_a), 32'(a));
                chk($sformatf("rnd%0d.orig_b", n), 32'(out_b), 32'(b));
                chk($sformatf("rnd%0d.orig_err", n), 32'(out_err), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
